adc_frontend: RTL and testbench

- Conditioning stage directly upstream of pdh_core: takes the raw dual-channel ADC AXI-Stream and drives pdh_core's adc_tdata_i/adc_tvalid_i.
- Per channel: sign-extends the 14-bit sample, adds a signed calibration offset with saturation, then boxcar-averages and decimates by a runtime-selectable 2^k.
- Reports sticky per-channel saturation flags for PS readback.

---
 rtl/pdh_pkg.sv | 35 +++
 rtl/adc_lane.sv | 58 +++++
 rtl/adc_frontend.sv | 116 +++++++++++
 tb/tb_adc_frontend.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdh_pkg.sv
// Shared constants and helpers for the ADC conditioning front end.
// Holds lane geometry, widths and the 17-to-16-bit saturator.
package pdh_pkg;

  localparam int ADC_W        = 14;
  localparam int OUT_W        = 16;
  localparam int MAX_LOG2_AVG = 6;
  localparam int ACC_W        = OUT_W + MAX_LOG2_AVG;

  localparam int LANE_A_LSB = 0;
  localparam int LANE_B_LSB = 16;

  typedef struct packed {
    logic [OUT_W-1:0] val;
    logic             ovf;
  } sat_t;

  // Top two bits disagree only when the value left the 16-bit range.
  function automatic sat_t sat16(input logic [OUT_W:0] x);
    sat_t r;
    r.ovf = x[OUT_W] ^ x[OUT_W-1];
    if (!r.ovf)
      r.val = x[OUT_W-1:0];
    else if (x[OUT_W])
      r.val = 16'h8000;
    else
      r.val = 16'h7FFF;
    return r;
  endfunction

  function automatic logic [2:0] clamp_k(input logic [2:0] k);
    return (k > 3'(MAX_LOG2_AVG)) ? 3'(MAX_LOG2_AVG) : k;
  endfunction

endpackage

// File: rtl/adc_lane.sv
// One ADC channel: sign-extend, offset add, saturate, boxcar sum, shift.
// Ports: i_raw/i_vld raw beat, i_offset, i_s1_vld/i_first/i_last/i_k
// window control from the top, o_ovf clamp flag, o_avg window result.
module adc_lane
  import pdh_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ADC_W-1:0] i_raw,
  input  logic             i_vld,
  input  logic [OUT_W-1:0] i_offset,
  input  logic             i_s1_vld,
  input  logic             i_first,
  input  logic             i_last,
  input  logic [2:0]       i_k,
  output logic             o_ovf,
  output logic [OUT_W-1:0] o_avg
);

  logic [OUT_W:0]          w_sum;
  sat_t                    w_sat;
  logic [OUT_W-1:0]        r_s1;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_s1_ext;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W-1:0] w_shift;
  logic [OUT_W-1:0]        r_avg;

  assign w_sum = {{(OUT_W+1-ADC_W){i_raw[ADC_W-1]}}, i_raw}
               + {i_offset[OUT_W-1], i_offset};
  assign w_sat = sat16(w_sum);
  assign o_ovf = w_sat.ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_s1 <= '0;
    else if (i_vld)
      r_s1 <= w_sat.val;
  end

  assign w_s1_ext  = {{(ACC_W-OUT_W){r_s1[OUT_W-1]}}, r_s1};
  assign w_acc_nxt = i_first ? w_s1_ext : r_acc + w_s1_ext;
  assign w_shift   = w_acc_nxt >>> i_k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_avg <= '0;
    end else if (i_s1_vld) begin
      r_acc <= w_acc_nxt;
      if (i_last)
        r_avg <= w_shift[OUT_W-1:0];
    end
  end

  assign o_avg = r_avg;

endmodule

// File: rtl/adc_frontend.sv
// Dual-lane ADC conditioning ahead of pdh_core: offset, saturate, 2^k average.
// Ports: s_axis_* raw input, avg_sel_i/offset_*_i config, clr_ovf_i,
// m_axis_* conditioned output, ovf_o sticky clamp flags.
module adc_frontend
  import pdh_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_tdata_i,
  input  logic        s_axis_tvalid_i,
  input  logic [2:0]  avg_sel_i,
  input  logic [15:0] offset_a_i,
  input  logic [15:0] offset_b_i,
  input  logic        clr_ovf_i,
  output logic [31:0] m_axis_tdata_o,
  output logic        m_axis_tvalid_o,
  output logic [1:0]  ovf_o
);

  logic             r_s1_vld;
  logic [5:0]       r_cnt;
  logic [2:0]       r_k;
  logic             r_done;
  logic [1:0]       r_ovf;
  logic [31:0]      r_tdata;
  logic             r_tvalid;
  logic [2:0]       w_k_sel;
  logic [2:0]       w_k;
  logic [5:0]       w_mask;
  logic             w_first;
  logic             w_last;
  logic             w_ovf_a;
  logic             w_ovf_b;
  logic [OUT_W-1:0] w_avg_a;
  logic [OUT_W-1:0] w_avg_b;
  logic             w_unused;

  assign w_unused = ^{s_axis_tdata_i[15:14], s_axis_tdata_i[31:30]};

  // An open window keeps its latched k; a new one takes the live setting.
  assign w_k_sel = clamp_k(avg_sel_i);
  assign w_first = (r_cnt == 6'd0);
  assign w_k     = w_first ? w_k_sel : r_k;
  assign w_mask  = 6'((7'd1 << w_k) - 7'd1);
  assign w_last  = (r_cnt == w_mask);

  adc_lane u_lane_a (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (s_axis_tdata_i[LANE_A_LSB +: ADC_W]),
    .i_vld    (s_axis_tvalid_i),
    .i_offset (offset_a_i),
    .i_s1_vld (r_s1_vld),
    .i_first  (w_first),
    .i_last   (w_last),
    .i_k      (w_k),
    .o_ovf    (w_ovf_a),
    .o_avg    (w_avg_a)
  );

  adc_lane u_lane_b (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (s_axis_tdata_i[LANE_B_LSB +: ADC_W]),
    .i_vld    (s_axis_tvalid_i),
    .i_offset (offset_b_i),
    .i_s1_vld (r_s1_vld),
    .i_first  (w_first),
    .i_last   (w_last),
    .i_k      (w_k),
    .o_ovf    (w_ovf_b),
    .o_avg    (w_avg_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_cnt    <= '0;
      r_k      <= '0;
      r_done   <= 1'b0;
    end else begin
      r_s1_vld <= s_axis_tvalid_i;
      r_done   <= r_s1_vld & w_last;
      if (r_s1_vld) begin
        if (w_first)
          r_k <= w_k_sel;
        r_cnt <= w_last ? 6'd0 : r_cnt + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else begin
      r_tvalid <= r_done;
      if (r_done)
        r_tdata <= {w_avg_b, w_avg_a};
    end
  end

  // New clamps OR in after the clear so a simultaneous set survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ovf <= '0;
    else
      r_ovf <= (r_ovf & ~{2{clr_ovf_i}})
             | ({w_ovf_b, w_ovf_a} & {2{s_axis_tvalid_i}});
  end

  assign m_axis_tdata_o  = r_tdata;
  assign m_axis_tvalid_o = r_tvalid;
  assign ovf_o           = r_ovf;

endmodule

// File: tb/tb_adc_frontend.sv
// Scoreboard bench for adc_frontend.
// Beats push expected words; a negedge monitor pops and checks them.
module tb_adc_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axis_tdata_i;
  logic        s_axis_tvalid_i;
  logic [2:0]  avg_sel_i;
  logic [15:0] offset_a_i;
  logic [15:0] offset_b_i;
  logic        clr_ovf_i;
  logic [31:0] m_axis_tdata_o;
  logic        m_axis_tvalid_o;
  logic [1:0]  ovf_o;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_pulse = 0;
  int   m_cnt = 0;
  int   m_k = 0;
  int   m_acc_a = 0;
  int   m_acc_b = 0;

  adc_frontend dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tdata_i  (s_axis_tdata_i),
    .s_axis_tvalid_i (s_axis_tvalid_i),
    .avg_sel_i       (avg_sel_i),
    .offset_a_i      (offset_a_i),
    .offset_b_i      (offset_b_i),
    .clr_ovf_i       (clr_ovf_i),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .ovf_o           (ovf_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_axis_tvalid_o) begin
      exp_t e;
      n_pulse++;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse got=%h at cyc %0d", m_axis_tdata_o, cyc);
      end else begin
        e = q.pop_front();
        if (m_axis_tdata_o !== e.d || cyc !== e.c) begin
          n_fail++;
          $display("FAIL sb_word got=%h@%0d want=%h@%0d",
                   m_axis_tdata_o, cyc, e.d, e.c);
        end
      end
    end
  end

  function automatic int msat(input logic [13:0] x, input logic [15:0] off);
    int v;
    v = int'($signed(x)) + int'($signed(off));
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic beat(input logic [13:0] a, input logic [13:0] b,
                      input logic clr = 1'b0);
    int sa;
    int sb;
    @(posedge clk); #1;
    s_axis_tdata_i  = {2'b11, b, 2'b11, a};
    s_axis_tvalid_i = 1'b1;
    clr_ovf_i       = clr;
    sa = msat(a, offset_a_i);
    sb = msat(b, offset_b_i);
    if (m_cnt == 0) begin
      m_k = (int'(avg_sel_i) > 6) ? 6 : int'(avg_sel_i);
      m_acc_a = sa;
      m_acc_b = sb;
    end else begin
      m_acc_a += sa;
      m_acc_b += sb;
    end
    if (m_cnt == (1 << m_k) - 1) begin
      q.push_back('{d: {16'(m_acc_b >>> m_k), 16'(m_acc_a >>> m_k)},
                    c: cyc + 3});
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_axis_tvalid_i = 1'b0;
      s_axis_tdata_i  = '0;
      clr_ovf_i       = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    idle(6);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing got=%0d pending want=0", tag, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (m_axis_tdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_tdata got=%h want=0", m_axis_tdata_o);
    end
    n_tests++;
    if (m_axis_tvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_tvalid got=%b want=0", m_axis_tvalid_o);
    end
    n_tests++;
    if (ovf_o !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_ovf got=%b want=00", ovf_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_passthrough;
    int p0;
    p0 = n_pulse;
    avg_sel_i = 3'd0;
    beat(14'h1FFF, 14'h2000);
    drain("pass");
    n_tests++;
    if (m_axis_tdata_o !== 32'hE000_1FFF || n_pulse - p0 != 1) begin
      n_fail++;
      $display("FAIL pass_word got=%h/%0d want=e0001fff/1",
               m_axis_tdata_o, n_pulse - p0);
    end
  endtask

  task automatic test_reset_mid;
    int p0;
    avg_sel_i = 3'd2;
    beat(14'd1, 14'd1);
    beat(14'd2, 14'd2);
    idle(1);
    rst = 1'b1;
    q.delete();
    m_cnt = 0;
    p0 = n_pulse;
    @(negedge clk);
    n_tests++;
    if (m_axis_tdata_o !== 32'h0 || m_axis_tvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_out got=%h/%b want=0/0",
               m_axis_tdata_o, m_axis_tvalid_o);
    end
    idle(2);
    rst = 1'b0;
    idle(4);
    n_tests++;
    if (n_pulse != p0) begin
      n_fail++;
      $display("FAIL midrst_stale got=%0d pulses want=0", n_pulse - p0);
    end
    beat(14'd4, -14'sd4);
    beat(14'd4, -14'sd4);
    beat(14'd4, -14'sd4);
    beat(14'd8, -14'sd4);
    drain("midrst");
    n_tests++;
    if (m_axis_tdata_o !== 32'hFFFC_0005 || n_pulse - p0 != 1) begin
      n_fail++;
      $display("FAIL midrst_word got=%h/%0d want=fffc0005/1",
               m_axis_tdata_o, n_pulse - p0);
    end
  endtask

  task automatic test_average;
    int p0;
    p0 = n_pulse;
    avg_sel_i = 3'd2;
    beat(14'd100, -14'sd1);
    beat(14'd101, -14'sd2);
    beat(14'd102, -14'sd2);
    beat(14'd103, -14'sd2);
    drain("avg");
    n_tests++;
    if (m_axis_tdata_o !== 32'hFFFE_0065 || n_pulse - p0 != 1) begin
      n_fail++;
      $display("FAIL avg_word got=%h/%0d want=fffe0065/1",
               m_axis_tdata_o, n_pulse - p0);
    end
  endtask

  task automatic test_gaps;
    int p0;
    p0 = n_pulse;
    avg_sel_i = 3'd1;
    beat(14'd10, 14'd0);
    idle(5);
    beat(14'd13, 14'd0);
    drain("gap");
    n_tests++;
    if (m_axis_tdata_o[15:0] !== 16'd11 || n_pulse - p0 != 1) begin
      n_fail++;
      $display("FAIL gap_word got=%h/%0d want=000b/1",
               m_axis_tdata_o[15:0], n_pulse - p0);
    end
  endtask

  task automatic test_saturation;
    avg_sel_i  = 3'd0;
    offset_a_i = 16'h7FFF;
    beat(14'd8191, 14'd0);
    drain("sat");
    n_tests++;
    if (m_axis_tdata_o[15:0] !== 16'h7FFF || ovf_o !== 2'b01) begin
      n_fail++;
      $display("FAIL sat_word got=%h ovf=%b want=7fff ovf=01",
               m_axis_tdata_o[15:0], ovf_o);
    end
    beat(14'd8191, 14'd0, 1'b1);
    drain("sat_clr");
    n_tests++;
    if (ovf_o !== 2'b01) begin
      n_fail++;
      $display("FAIL sat_setwins got=%b want=01", ovf_o);
    end
    offset_a_i = 16'h0;
    @(posedge clk); #1;
    clr_ovf_i = 1'b1;
    @(posedge clk); #1;
    clr_ovf_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ovf_o !== 2'b00) begin
      n_fail++;
      $display("FAIL sat_clear got=%b want=00", ovf_o);
    end
    offset_b_i = 16'h8000;
    beat(-14'sd1, -14'sd8192);
    drain("satb");
    n_tests++;
    if (m_axis_tdata_o !== 32'h8000_FFFF || ovf_o !== 2'b10) begin
      n_fail++;
      $display("FAIL satb_word got=%h ovf=%b want=8000ffff ovf=10",
               m_axis_tdata_o, ovf_o);
    end
    offset_b_i = 16'h0;
  endtask

  task automatic test_config_change;
    int p0;
    p0 = n_pulse;
    avg_sel_i = 3'd2;
    beat(14'd4, 14'd1);
    idle(2);
    avg_sel_i = 3'd0;
    beat(14'd8, 14'd1);
    beat(14'd12, 14'd1);
    beat(14'd16, 14'd1);
    beat(14'd7, 14'd2);
    beat(-14'sd3, 14'd3);
    beat(14'd100, 14'd4);
    drain("cfg");
    n_tests++;
    if (n_pulse - p0 != 4 || m_axis_tdata_o !== 32'h0004_0064) begin
      n_fail++;
      $display("FAIL cfg_pulses got=%0d/%h want=4/00040064",
               n_pulse - p0, m_axis_tdata_o);
    end
  endtask

  task automatic test_clamp_k;
    int p0;
    p0 = n_pulse;
    avg_sel_i = 3'd7;
    for (int i = 0; i < 64; i++)
      beat(14'(i), 14'd0);
    drain("clamp");
    n_tests++;
    if (n_pulse - p0 != 1 || m_axis_tdata_o[15:0] !== 16'd31) begin
      n_fail++;
      $display("FAIL clamp_word got=%0d/%h want=1/001f",
               n_pulse - p0, m_axis_tdata_o[15:0]);
    end
  endtask

  initial begin
    rst             = 1'b1;
    s_axis_tdata_i  = '0;
    s_axis_tvalid_i = 1'b0;
    avg_sel_i       = 3'd0;
    offset_a_i      = 16'h0;
    offset_b_i      = 16'h0;
    clr_ovf_i       = 1'b0;
    test_reset;
    test_passthrough;
    test_reset_mid;
    test_average;
    test_gaps;
    test_saturation;
    test_config_change;
    test_clamp_k;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
